// File: rtl/pc_halt_monitor_if.sv
// Bundles the pc sample stream and the verdict outputs of pc_halt_monitor.
// master drives pc samples (CPU side / harness); slave is the monitor itself.
interface pc_halt_monitor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  halt;
  logic                  trap;
  logic                  done;
  logic [1:0]            trap_cause;
  logic [ADDR_WIDTH-1:0] halt_pc;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    output pc, pc_valid,
    input  halt, trap, done, trap_cause, halt_pc, cycle_count
  );

  modport slave (
    input  pc, pc_valid,
    output halt, trap, done, trap_cause, halt_pc, cycle_count
  );
endinterface

// File: rtl/pc_halt_monitor.sv
// Watches the CPU pc stream and reports a sticky halt (self-loop) or trap verdict.
// Define PC_HALT_MONITOR_TIMEOUT_EN to enable the run-timeout trap (cause 3).
module pc_halt_monitor #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            CNT_WIDTH   = 32,
  parameter int unsigned            STALL_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0]  TRAP_ADDR   = ADDR_WIDTH'(32'h4)
`ifdef PC_HALT_MONITOR_TIMEOUT_EN
  ,
  parameter int unsigned            TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  pc_halt_monitor_if.slave  mon
);

  localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HALTED  = 2'd1,
    S_TRAPPED = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] prev_pc_q;
  logic                  have_prev_q;
  logic [RUN_W-1:0]      run_len_q;
  logic                  halt_q;
  logic                  trap_q;
  logic                  done_q;
  logic [1:0]            cause_q;
  logic [ADDR_WIDTH-1:0] halt_pc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  same_d;
  logic [RUN_W-1:0]      run_len_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  misalign_d;
  logic                  trap_addr_d;
  logic                  timeout_d;
  logic                  stall_hit_d;

  // Per-sample evaluation of the incoming pc against the current run.
  always_comb begin
    same_d      = have_prev_q && (mon.pc == prev_pc_q);
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    run_len_d   = RUN_W'(1);
    if (same_d) begin
      run_len_d = (run_len_q == RUN_W'(STALL_LIMIT)) ? run_len_q : run_len_q + RUN_W'(1);
    end
    misalign_d  = (mon.pc[1:0] != 2'b00);
    trap_addr_d = (mon.pc == TRAP_ADDR);
`ifdef PC_HALT_MONITOR_TIMEOUT_EN
    timeout_d   = (cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    timeout_d   = 1'b0;
`endif
    stall_hit_d = same_d && (run_len_q == RUN_W'(STALL_LIMIT - 1));
  end

  // Verdict FSM; terminal states freeze every register until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      prev_pc_q   <= '0;
      have_prev_q <= 1'b0;
      run_len_q   <= '0;
      halt_q      <= 1'b0;
      trap_q      <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'd0;
      halt_pc_q   <= '0;
      cnt_q       <= '0;
    end else if ((state_q == S_RUN) && mon.pc_valid) begin
      cnt_q       <= cnt_d;
      prev_pc_q   <= mon.pc;
      have_prev_q <= 1'b1;
      run_len_q   <= run_len_d;
      // Trap causes outrank the self-loop halt on the same sample.
      if (misalign_d || trap_addr_d || timeout_d) begin
        state_q   <= S_TRAPPED;
        trap_q    <= 1'b1;
        done_q    <= 1'b1;
        halt_pc_q <= mon.pc;
        if (misalign_d) begin
          cause_q <= 2'd1;
        end else if (trap_addr_d) begin
          cause_q <= 2'd2;
        end else begin
          cause_q <= 2'd3;
        end
      end else if (stall_hit_d) begin
        state_q   <= S_HALTED;
        halt_q    <= 1'b1;
        done_q    <= 1'b1;
        halt_pc_q <= mon.pc;
      end
    end
  end

  assign mon.halt        = halt_q;
  assign mon.trap        = trap_q;
  assign mon.done        = done_q;
  assign mon.trap_cause  = cause_q;
  assign mon.halt_pc     = halt_pc_q;
  assign mon.cycle_count = cnt_q;

endmodule
